// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and types for the regfile_sb register file
//               with integrated busy-bit scoreboard. Holds the default
//               configuration (32 x 32-bit, two read ports), the register
//               address type for that configuration and the index of the
//               hardwired zero register.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_NREGS  = 32;
    localparam int c_NREAD  = 2;
    localparam int c_ADDR_W = $clog2(c_NREGS);

    typedef logic [c_ADDR_W-1:0] reg_addr_t;

    // Register 0 reads as zero, is never busy and ignores writes and issues.
    localparam reg_addr_t c_ZERO_REG = reg_addr_t'(0);

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Busy-bit vector for the register file. A register is marked
//               busy when an instruction writing it issues and is cleared when
//               its writeback arrives. Priority per posedge, lowest first:
//               writeback clear, issue set, flush (clears everything).
//               Bit 0 is never busy.
// Ports       : clock          - clock, state updates on posedge
//               ctrl_reset_n   - asynchronous active-low reset
//               wr_en_i        - writeback valid
//               wr_reg_i       - writeback destination
//               iss_en_i       - issue valid
//               iss_reg_i      - issued destination
//               flush_i        - clear all busy bits
//               busy_vec_o     - current busy bits
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = c_NREGS,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_reg_i,
    input  logic              iss_en_i,
    input  logic [ADDR_W-1:0] iss_reg_i,
    input  logic              flush_i,
    output logic [NREGS-1:0]  busy_vec_o
);

    logic [NREGS-1:0] r_busy_q;
    logic [NREGS-1:0] w_busy_d;

    always_comb begin
        w_busy_d = r_busy_q;
        if (flush_i) begin
            w_busy_d = '0;
        end else begin
            if (wr_en_i && (wr_reg_i != ADDR_W'(c_ZERO_REG))) begin
                w_busy_d[wr_reg_i] = 1'b0;
            end
            // Issue after writeback: the new producer is still outstanding.
            if (iss_en_i && (iss_reg_i != ADDR_W'(c_ZERO_REG))) begin
                w_busy_d[iss_reg_i] = 1'b1;
            end
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_busy_q <= '0;
        end else begin
            r_busy_q <= w_busy_d;
        end
    end

    assign busy_vec_o = r_busy_q;

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Parametrised multi-read-port register file with busy-bit
//               scoreboard. Combinational reads, one writeback port (writes
//               data, clears busy), one issue port (sets busy). Register 0 is
//               hardwired to zero and never busy.
// Build macro : REGFILE_BYPASS_EN - when defined, a writeback forwards its
//               data to any read port addressing the same register in the
//               same cycle, with read_ready forced high.
// Ports       : clock            - clock, state updates on posedge
//               ctrl_reset_n     - asynchronous active-low reset
//               ctrl_writeEnable - writeback valid
//               ctrl_writeReg    - writeback destination
//               data_writeReg    - writeback data
//               ctrl_issueEnable - issue valid
//               ctrl_issueReg    - issued destination
//               ctrl_flush       - clear all busy bits
//               ctrl_readReg     - read addresses, one per port
//               data_readReg     - read data, one per port
//               read_ready       - per-port "data not pending"
//               busy_vec         - current busy bits
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int NREGS  = c_NREGS,
    parameter int NREAD  = c_NREAD,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic                         clock,
    input  logic                         ctrl_reset_n,
    input  logic                         ctrl_writeEnable,
    input  logic [ADDR_W-1:0]            ctrl_writeReg,
    input  logic [DATA_W-1:0]            data_writeReg,
    input  logic                         ctrl_issueEnable,
    input  logic [ADDR_W-1:0]            ctrl_issueReg,
    input  logic                         ctrl_flush,
    input  logic [NREAD-1:0][ADDR_W-1:0] ctrl_readReg,
    output logic [NREAD-1:0][DATA_W-1:0] data_readReg,
    output logic [NREAD-1:0]             read_ready,
    output logic [NREGS-1:0]             busy_vec
);

    logic [NREGS-1:0][DATA_W-1:0] r_regs_q;
    logic [NREGS-1:0]             w_busy;
    logic                         w_wr_valid;

    assign w_wr_valid = ctrl_writeEnable && (ctrl_writeReg != ADDR_W'(c_ZERO_REG));

    // Data storage; entry 0 is only ever reset and never written.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_regs_q <= '0;
        end else if (w_wr_valid) begin
            r_regs_q[ctrl_writeReg] <= data_writeReg;
        end
    end

    reg_scoreboard #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .wr_en_i      (ctrl_writeEnable),
        .wr_reg_i     (ctrl_writeReg),
        .iss_en_i     (ctrl_issueEnable),
        .iss_reg_i    (ctrl_issueReg),
        .flush_i      (ctrl_flush),
        .busy_vec_o   (w_busy)
    );

    assign busy_vec = w_busy;

    // Read ports. Register state is already zero while in reset, so the only
    // path that needs explicit reset gating is the write forwarding.
    always_comb begin
        data_readReg = '0;
        read_ready   = '1;
        for (int p = 0; p < NREAD; p++) begin
            if (ctrl_readReg[p] != ADDR_W'(c_ZERO_REG)) begin
                data_readReg[p] = r_regs_q[ctrl_readReg[p]];
                read_ready[p]   = ~w_busy[ctrl_readReg[p]];
            end
`ifdef REGFILE_BYPASS_EN
            if (ctrl_reset_n && w_wr_valid && (ctrl_writeReg == ctrl_readReg[p])) begin
                data_readReg[p] = data_writeReg;
                read_ready[p]   = 1'b1;
            end
`endif
        end
    end

endmodule : regfile_sb
`default_nettype wire
